// File: rtl/drum_audio_tap.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | drum_audio_tap: mesh node displacement -> decimated, saturated PCM FIFO    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module drum_audio_tap #(
  parameter int SHIFT = 2,
  parameter int DECIM = 1,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [17:0]                u_in,
  input  logic                       valid_in,
  output logic [15:0]                sample_out,
  output logic                       sample_valid,
  input  logic                       sample_ready,
  output logic                       fifo_full,
  output logic [$clog2(DEPTH):0]     fifo_level,
  output logic [15:0]                drop_count
);

  localparam int c_AW = $clog2(DEPTH);
  localparam int c_CW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [c_AW:0]   c_DEPTH_L  = (c_AW + 1)'(DEPTH);
  localparam logic [c_CW-1:0] c_DEC_LAST = c_CW'(DECIM - 1);

  logic                 r_valid_d;
  logic [c_CW-1:0]      r_dec_cnt;
  logic [c_AW-1:0]      r_wr_ptr;
  logic [c_AW-1:0]      r_rd_ptr;
  logic [c_AW:0]        r_level;
  logic [15:0]          r_drop;
  logic [15:0]          r_mem [DEPTH];

  logic signed [17:0]   w_shifted;
  logic [15:0]          w_sat;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_full;
  logic                 w_wr_en;
  logic                 w_drop;

  // The node updates u on the edge closing its strobe cycle, so u is read one cycle later.
  assign w_push  = r_valid_d && (r_dec_cnt == '0);
  assign w_full  = (r_level == c_DEPTH_L);
  assign w_pop   = (r_level != '0) && sample_ready;
  assign w_wr_en = w_push && (!w_full || w_pop);
  assign w_drop  = w_push && w_full && !w_pop;

  assign w_shifted = $signed(u_in) >>> SHIFT;

  always_comb begin
    w_sat = w_shifted[15:0];
    if (w_shifted[17:15] != 3'b000 && w_shifted[17:15] != 3'b111) begin
      w_sat = w_shifted[17] ? 16'h8000 : 16'h7FFF;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid_d <= 1'b0;
      r_dec_cnt <= '0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_level   <= '0;
      r_drop    <= '0;
    end else begin
      r_valid_d <= valid_in;
      if (r_valid_d) begin
        r_dec_cnt <= (r_dec_cnt == c_DEC_LAST) ? '0 : r_dec_cnt + 1'b1;
      end
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_wr_en, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
      if (w_drop && r_drop != 16'hFFFF) begin
        r_drop <= r_drop + 1'b1;
      end
    end
  end

  // Storage carries no reset; stale words are hidden by the empty mask below.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr] <= w_sat;
    end
  end

  assign sample_valid = (r_level != '0);
  assign sample_out   = sample_valid ? r_mem[r_rd_ptr] : 16'h0000;
  assign fifo_full    = w_full;
  assign fifo_level   = r_level;
  assign drop_count   = r_drop;

endmodule
`default_nettype wire

// File: doc/drum_audio_tap.md
# drum_audio_tap

Downstream consumer of one FDN drum mesh node (typically the strike-point or pickup node). Captures the node's displacement `u` after every mesh update, optionally decimates, converts the 18-bit fixed-point value to 16-bit saturated PCM, and buffers it in a small first-word-fall-through FIFO. The FIFO drains to the audio codec serializer over a valid/ready handshake. Also reports overflow drops so software can tune the mesh update rate.

## Interface

Parameters:
- `SHIFT`, 2, arithmetic right shift applied to `u` before saturation (0..4).
- `DECIM`, 1, keep one of every `DECIM` mesh updates (1..256).
- `DEPTH`, 8, FIFO depth in samples, power of two ≥ 2.

Ports:
- `clk`  in  1  system clock; one clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `u_in`  in  18  signed node displacement, 2.16 fixed point (0x1_0000 = 1.0).
- `valid_in`  in  1  node update strobe; high in the node's update cycle.
- `sample_out`  out  16  signed PCM at FIFO head.
- `sample_valid`  out  1  FIFO non-empty.
- `sample_ready`  in  1  consumer accepts head this cycle.
- `fifo_full`  out  1  FIFO holds `DEPTH` samples.
- `fifo_level`  out  clog2(DEPTH)+1  current occupancy.
- `drop_count`  out  16  saturating count of samples lost to overflow.

## Operation

- **Capture alignment.** The node writes its new `u` on the same edge that ends its `valid_in` cycle. Therefore:
  - `valid_in` is registered into `valid_d`.
  - `u_in` is sampled in the cycle where `valid_d` = 1, never in the `valid_in` cycle itself.
- **Decimation.**
  - `dec_cnt` runs 0..`DECIM`-1 and advances on every capture, wrapping to 0.
  - A capture produces a push only when `dec_cnt` = 0 before the advance.
  - The first capture after reset is always pushed.
- **Conversion.**
  - `s = u_in >>> SHIFT`, arithmetic shift, 18-bit.
  - Saturate `s` to [-32768, 32767].
  - The result is written to the FIFO, not held in a separate register.
- **FIFO.**
  - Circular buffer with read/write pointers of clog2(DEPTH) bits that wrap naturally.
  - Occupancy counter runs 0..DEPTH.
  - `sample_out` = mem[rd_ptr]. `sample_valid` = (level ≠ 0). `fifo_full` = (level = DEPTH).
- **Pop.** Occurs when `sample_valid` && `sample_ready`. Popping while empty is ignored.
- **Push while full.**
  - If a pop happens in the same cycle, both proceed and level is unchanged.
  - Otherwise the sample is discarded and `drop_count` increments, saturating at 0xFFFF.
- **Simultaneous push and pop when not full.** Both proceed and level is unchanged.
- **Reset.**
  - Clears `valid_d`, `dec_cnt`, pointers, level and `drop_count`.
  - Outputs are 0: `sample_valid`=0, `fifo_full`=0, `fifo_level`=0, `drop_count`=0, `sample_out`=0 (mem contents are don't-care but masked to 0 while empty).
  - Reset mid-operation discards all buffered samples and any pending `valid_d`.

## Timing

- Cycle t: `valid_in`=1. Edge ending t: `valid_d`←1.
- Cycle t+1: `u_in` converted combinationally. Edge ending t+1: FIFO write if selected.
- Cycle t+2: if the FIFO was empty, `sample_valid`=1 and `sample_out` = new sample.
- Latency `valid_in` → `sample_valid` = 2 cycles.
- Back-to-back `valid_in` on consecutive cycles is supported at one push per cycle.
- Pop takes effect at the edge; the next head is visible the following cycle.
- `fifo_level`, `fifo_full` and `drop_count` are registered and reflect the state after each edge.

## Test plan

1. **Basic capture.** Reset, then `valid_in` for 1 cycle with `u_in` changing to 0x1_0000 on the following cycle. Required: `sample_out`=0x4000 and `sample_valid`=1 exactly 2 cycles after `valid_in`; `fifo_level`=1.
2. **Saturation**, `SHIFT`=0.
   - `u_in`=0x1_0000 → 0x7FFF.
   - `u_in`=0x3_0000 (-1.0) → 0x8000.
   - `u_in`=0x0_1234 → 0x1234.
3. **Decimation**, `DECIM`=4, `sample_ready`=0. Eight captures with `u_in` = 1..8 (×4 at `SHIFT`=2). Required: `fifo_level`=2, popped samples are 1 then 5.
4. **Overflow**, `DEPTH`=8, `sample_ready`=0. Ten captures. Required: `fifo_full`=1, `fifo_level`=8, `drop_count`=2; the first pop returns the first captured sample.
5. **Push and pop when full.** With the FIFO full, `sample_ready`=1 in the same cycle a push lands. Required: `drop_count` unchanged, `fifo_level` stays 8, write pointer wraps correctly over 20 further cycles of this pattern.
6. **Reset mid-operation.** `fifo_level`=4 and `valid_in` pulsed the cycle before `reset`. Required: after the reset edge `fifo_level`=0, `sample_valid`=0, `drop_count`=0, and no sample from the pending pulse appears.
